cache_fill_fsm: RTL
===================

// Module: cache_fill_fsm
// PURPOSE
//  Miss-handling controller directly upstream of the cache data array.
//  On a cache miss it fetches one 16 B block (8 x 16-bit words) from pipelined main memory.
//  It steers each returned word into the data array via a 3-bit word select and write strobe.
//  After the 8th word it strobes the tag array, then returns to idle.
// PARAMETERS
//  WORDS_PER_BLOCK  8   words per cache block; word_sel width is log2 of this (3)
//  MEM_LATENCY      4   cycles from mem_read_en to matching memory_data_valid
//  ADDR_W           16  byte-address width
// PORTS
//  clk                input   1       system clock, all state updates on rising edge
//  rst                input   1       asynchronous, active-low reset
//  miss_detected      input   1       level: current access missed in cache
//  miss_address       input   ADDR_W  byte address of the missing access
//  memory_data_valid  input   1       memory returning a word this cycle (in issue order)
//  fsm_busy           output  1       fill in progress; pipeline must stall
//  mem_read_en        output  1       issue a word read to memory this cycle
//  memory_address     output  ADDR_W  byte address of the word being requested
//  write_data_array   output  1       write memory data into the data array this cycle
//  word_sel           output  3       word index within the block for the data-array write
//  write_tag_array    output  1       one-cycle strobe: install tag/valid for the filled block
//  fill_done          output  1       one-cycle pulse, coincident with write_tag_array
// BEHAVIOUR
//  - Reset (rst=0, asynchronous): state=IDLE, all counters and base address 0.
//  - Reset values: all outputs 0, including memory_address=0.
//  - States: IDLE, FILL.
//  - IDLE: if miss_detected=1 at an edge:
//    - latch base = miss_address & ~16'h000F;
//    - clear issue_cnt and recv_cnt;
//    - go to FILL.
//  - IDLE: memory_data_valid is ignored.
//  - FILL: fsm_busy=1.
//  - FILL: mem_read_en=1 while issue_cnt<8; memory_address = base + 2*issue_cnt.
//    - issue_cnt increments on each issue; 8 consecutive issue cycles, no gaps.
//  - FILL: write_data_array = memory_data_valid; word_sel = recv_cnt[2:0].
//    - recv_cnt increments on each valid.
//  - When memory_data_valid=1 with recv_cnt=7:
//    - write_tag_array=1 and fill_done=1 that same cycle;
//    - next state IDLE.
//  - Latency: miss accepted at edge k gives requests in cycles k+1..k+8.
//    - With MEM_LATENCY=4, writes occur in cycles k+5..k+12.
//    - fill_done occurs in cycle k+12; fsm_busy=0 from cycle k+13.
//  - miss_detected is ignored while in FILL, including the fill_done cycle.
//    - A still-asserted miss is accepted at the first IDLE edge.
//  - Address arithmetic is ADDR_W wide, modulo 2^ADDR_W.
//    - The block never crosses its 16 B aligned base; no carry out of bits [3:1].
//  - All outputs are decoded from registered state/counters plus memory_data_valid.
//    - No other combinational input-to-output paths.
//  - Reset mid-fill: abort immediately to IDLE.
//    - No write_tag_array or fill_done for the aborted block.
//    - Partial data-array writes are left as-is; the tag stays invalid.
// TESTING
//  1. Miss 0x1234, MEM_LATENCY=4, data D0..D7 returned ->
//     - memory_address 0x1230,0x1232..0x123E on 8 consecutive cycles;
//     - word_sel 0..7 with write_data_array;
//     - write_tag_array and fill_done at k+12; fsm_busy low at k+13.
//  2. Hold miss_detected=1 through a whole fill of 0x0040, with miss_address changed to 0x0080 mid-fill ->
//     - only 0x0040..0x004E fetched;
//     - a new fill of 0x0080 starts the cycle after fill_done.
//  3. Assert rst=0 after 3 words returned for miss 0x2000 ->
//     - all outputs 0 immediately, no tag write;
//     - the next miss 0x3000 starts at word_sel=0.
//  4. Pulse memory_data_valid 3 times while IDLE ->
//     - write_data_array stays 0, word_sel stays 0;
//     - a subsequent fill still writes word_sel 0..7 correctly.
//  5. Miss 0xFFFE -> memory_address 0xFFF0..0xFFFE, no wrap past 0xFFFE.
//  6. Memory returns with gaps (valid on alternate cycles) ->
//     - word_sel still 0..7 in order;
//     - fill_done on the 8th valid; fsm_busy stays high until then.

Source files
------------

// File: rtl/cache_fill_fsm.sv
// Cache miss fill controller: fetches one aligned block from pipelined memory and
// steers the returned words into the data array, then strobes the tag array.
module cache_fill_fsm #(
  parameter int WORDS_PER_BLOCK = 8,
  parameter int MEM_LATENCY     = 4,
  parameter int ADDR_W          = 16
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               miss_detected,
  input  logic [ADDR_W-1:0]                  miss_address,
  input  logic                               memory_data_valid,
  output logic                               fsm_busy,
  output logic                               mem_read_en,
  output logic [ADDR_W-1:0]                  memory_address,
  output logic                               write_data_array,
  output logic [$clog2(WORDS_PER_BLOCK)-1:0] word_sel,
  output logic                               write_tag_array,
  output logic                               fill_done
);

  localparam int WSEL_W = $clog2(WORDS_PER_BLOCK);
  localparam int OFF_W  = WSEL_W + 1;  // byte offset bits within a block of 16-bit words
  localparam logic [WSEL_W-1:0] LAST = WSEL_W'(WORDS_PER_BLOCK - 1);

  if (WORDS_PER_BLOCK < 2 || (1 << WSEL_W) != WORDS_PER_BLOCK || MEM_LATENCY < 1) begin : g_param_chk
    $error("cache_fill_fsm: WORDS_PER_BLOCK must be a power of two >= 2 and MEM_LATENCY >= 1");
  end

  typedef enum logic {IDLE, FILL} state_t;

  state_t                   state;
  logic [ADDR_W-OFF_W-1:0]  base;
  logic [WSEL_W:0]          issue_cnt;  // MSB set means all words issued
  logic [WSEL_W-1:0]        recv_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      base      <= '0;
      issue_cnt <= '0;
      recv_cnt  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (miss_detected) begin
            base      <= miss_address[ADDR_W-1:OFF_W];
            issue_cnt <= '0;
            recv_cnt  <= '0;
            state     <= FILL;
          end
        end
        FILL: begin
          if (!issue_cnt[WSEL_W]) issue_cnt <= issue_cnt + 1'b1;
          if (memory_data_valid) begin
            recv_cnt <= recv_cnt + 1'b1;
            if (recv_cnt == LAST) state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Outputs are pure decode of state/counters; memory_data_valid is the only input
  // that reaches them, and only while filling.
  logic fill;
  assign fill             = (state == FILL);
  assign fsm_busy         = fill;
  assign mem_read_en      = fill & ~issue_cnt[WSEL_W];
  assign memory_address   = mem_read_en ? {base, issue_cnt[WSEL_W-1:0], 1'b0} : '0;
  assign write_data_array = fill & memory_data_valid;
  assign word_sel         = fill ? recv_cnt : '0;
  assign write_tag_array  = write_data_array & (recv_cnt == LAST);
  assign fill_done        = write_tag_array;

endmodule
